icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss-refill sequencer between the I-cache lookup logic and the downstream AHB-Lite master port. It accepts one miss request at a time and issues a critical-word-first WRAP4 read burst of 32-bit beats. It assembles the four beats into a 128-bit line and presents it once, with index and tag, for the cache array write. Bus errors abort the refill without writing the cache.

Parameters:
CACHE_SIZE, 8192, cache capacity in bytes (512 lines of 128 bits)
CACHE_LINE, 128, line width in bits; fixed at 4 words of 32 bits
IDX_W (localparam), $clog2(CACHE_SIZE*8/CACHE_LINE) = 9, index width
TAG_W (localparam), 32-IDX_W-4 = 19, tag width

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  1  miss request
req_ready  out  1  controller idle; request accepted when valid&ready
req_addr  in  32  byte address of missing word
fill_valid  out  1  one-cycle pulse: line complete
fill_index  out  IDX_W  req_addr[IDX_W+3:4] of the refill
fill_tag  out  TAG_W  req_addr[31:IDX_W+4] of the refill
fill_line  out  128  word w at bits [32w+31:32w]
crit_valid  out  1  critical word available (optional feature)
crit_data  out  32  critical word
err_valid  out  1  one-cycle pulse: refill aborted by HRESP error
haddr  out  32  AHB address
htrans  out  2  IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11
hburst  out  3  WRAP4 during refill, SINGLE otherwise
hsize  out  3  always WORD (3'b010)
hwrite  out  1  always 0
hready  in  1  AHB transfer ready
hrdata  in  32  AHB read data
hresp  in  1  AHB error response

Behaviour:
- Reset: synchronous, active-high.
  - State IDLE; req_ready=1; htrans=IDLE; haddr=0; hburst=SINGLE.
  - fill_valid, crit_valid and err_valid are 0; fill_line, crit_data, fill_index and fill_tag are 0.
- Reset mid-burst: the next edge returns to IDLE and drops the partial line. No fill_valid and no err_valid are issued.
- Address and data beats are pipelined. An address phase advances only on a cycle with hready=1. Data for beat n is sampled on the hready=1 edge of the cycle after beat n's address phase.
- Wrap address: beat n = {req_addr[31:4], req_addr[3:2]+n (mod 4), 2'b00}.
- IDLE: req_ready=1. On req_valid, latch req_addr and go to ADDR. req_valid while busy is ignored.
- ADDR: htrans=NONSEQ with the beat-0 address. haddr, htrans and hburst are held stable while hready=0. On hready, go to BURST.
- BURST:
  - Drive SEQ for beats 1..3, then htrans=IDLE.
  - Each hready=1 edge captures the pending data beat into line word (req_addr[3:2]+n mod 4).
  - When beat 3 data is captured, go to FILL.
- FILL: fill_valid=1 for one cycle, then go to IDLE.
- Zero-wait latency: request accepted at edge T; NONSEQ at T+1; fill_valid at T+6; req_ready at T+7.
- Error:
  - hresp=1 with hready=0 (first error cycle): force htrans=IDLE and go to ERR.
  - ERR: on hready=1, err_valid=1 for one cycle, then go to IDLE. No fill_valid.
  - Beats already captured are discarded.
- hresp=1 with hready=1 outside a data phase is ignored.

Optional Feature:
ICACHE_CRIT_WORD_FWD_EN
- Defined: the cycle after beat 0 data is captured, crit_valid=1 for one cycle and crit_data = beat 0 data. The CPU can restart before fill_valid.
- Not defined: crit_valid is tied 0 and crit_data is tied 0. The CPU waits for fill_valid.

Decomposition:
- interface_pkg additions:
  - HTRANS enum.
  - HSIZE_WORD constant.
  - refill_state_t enum (IDLE, ADDR, BURST, FILL, ERR).
  - Reuse the existing BURST_TYPES (WRAP4, SINGLE).
- Sub-module wrap4_addr_gen: given base address and beat count, produces the wrapped haddr and the line word slot. Combinational; the controller holds the counters.

Test Plan:
1. Zero-wait miss, req_addr=0x0000_1238, slave returns D0..D3.
   - haddr sequence 0x1238, 0x123C, 0x1230, 0x1234 (NONSEQ, SEQ, SEQ, SEQ).
   - fill_valid at T+6 with fill_line={D1,D0,D3,D2}, fill_index=9'h123, fill_tag=0.
2. Slave inserts hready=0 for 2 cycles on beat 1 → haddr=0x123C and htrans=SEQ held stable; fill_valid at T+8 with the same fill_line.
3. hresp=1 on beat 2 data phase (2-cycle error) → htrans=IDLE in the second error cycle, err_valid pulse, no fill_valid, req_ready=1 next cycle.
4. req_valid held high continuously with addresses 0x40 then 0x8000_0010 → second request is accepted only in the cycle req_ready returns (T+7). Second burst is 0x8000_0010, 0x14, 0x18, 0x1C with fill_tag=19'h40000.
5. rst asserted at T+3 → next edge: htrans=IDLE, req_ready=1, no fill_valid and no err_valid; a new request afterwards completes normally.
6. ICACHE_CRIT_WORD_FWD_EN defined → crit_valid at T+3 with crit_data=D0. Undefined → crit_valid stays 0 throughout.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// icache_refill_ctrl_pkg: shared AHB encodings and refill FSM states for the I-cache refill controller
// Contents: htrans_t (AHB transfer type), burst_t (AHB burst type), HSIZE_WORD, refill_state_t
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_WRAP4  = 3'b010
    } burst_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_FILL,
        ST_ERR
    } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl_wrap4_addr_gen.sv
// icache_refill_ctrl_wrap4_addr_gen: wrapped WRAP4 beat address and line word slot
// Ports: word_addr (request address [31:2]), beat (0..3) -> addr (byte address of beat), slot (line word of beat)
module icache_refill_ctrl_wrap4_addr_gen (
    input  logic [29:0] word_addr,
    input  logic [1:0]  beat,
    output logic [31:0] addr,
    output logic [1:0]  slot
);

    // 2-bit add wraps within the 16-byte line
    assign slot = word_addr[1:0] + beat;
    assign addr = {word_addr[29:2], slot, 2'b00};

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: I-cache miss refill sequencer issuing critical-word-first AHB WRAP4 read bursts
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_addr miss request handshake;
//        fill_valid/fill_index/fill_tag/fill_line completed line; crit_valid/crit_data critical word;
//        err_valid aborted refill; haddr/htrans/hburst/hsize/hwrite/hready/hrdata/hresp AHB-Lite master.
// Config: define ICACHE_CRIT_WORD_FWD_EN to forward beat-0 data on crit_valid/crit_data.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int CACHE_SIZE = 8192,
    parameter int CACHE_LINE = 128,
    localparam int IDX_W = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
    localparam int TAG_W = 32 - IDX_W - 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             fill_valid,
    output logic [IDX_W-1:0] fill_index,
    output logic [TAG_W-1:0] fill_tag,
    output logic [127:0]     fill_line,
    output logic             crit_valid,
    output logic [31:0]      crit_data,
    output logic             err_valid,
    output logic [31:0]      haddr,
    output logic [1:0]       htrans,
    output logic [2:0]       hburst,
    output logic [2:0]       hsize,
    output logic             hwrite,
    input  logic             hready,
    input  logic [31:0]      hrdata,
    input  logic             hresp
);

    refill_state_t state, state_nxt;
    logic [29:0]  base;
    logic [1:0]   cnt;
    logic [127:0] line;
    logic [1:0]   a_beat;
    logic [31:0]  wrap_addr;
    logic [1:0]   a_slot_unused;
    logic [31:0]  d_addr_unused;
    logic [1:0]   d_slot;
    logic         capture;
    logic         err_hit;
    logic         unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    // In BURST, cnt is the data beat in flight and cnt+1 the address beat on the bus
    assign a_beat  = (state == ST_ADDR) ? 2'd0 : cnt + 2'd1;
    assign capture = (state == ST_BURST) && hready;
    assign err_hit = (state == ST_BURST) && hresp && !hready;

    icache_refill_ctrl_wrap4_addr_gen u_addr_gen (
        .word_addr (base),
        .beat      (a_beat),
        .addr      (wrap_addr),
        .slot      (a_slot_unused)
    );

    icache_refill_ctrl_wrap4_addr_gen u_slot_gen (
        .word_addr (base),
        .beat      (cnt),
        .addr      (d_addr_unused),
        .slot      (d_slot)
    );

    assign hsize      = HSIZE_WORD;
    assign hwrite     = 1'b0;
    assign fill_line  = line;
    assign fill_index = base[IDX_W+1:2];
    assign fill_tag   = base[29:IDX_W+2];

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        htrans     = HT_IDLE;
        haddr      = '0;
        hburst     = BURST_SINGLE;
        fill_valid = 1'b0;
        err_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                htrans = HT_NONSEQ;
                haddr  = wrap_addr;
                hburst = BURST_WRAP4;
                if (hready) state_nxt = ST_BURST;
            end
            ST_BURST: begin
                // first error cycle cancels the next transfer
                htrans    = (err_hit || cnt == 2'd3) ? HT_IDLE : HT_SEQ;
                haddr     = wrap_addr;
                hburst    = BURST_WRAP4;
                state_nxt = err_hit ? ST_ERR : (hready && cnt == 2'd3) ? ST_FILL : ST_BURST;
            end
            ST_FILL: begin
                fill_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            ST_ERR: begin
                err_valid = hready;
                if (hready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            base  <= '0;
            cnt   <= '0;
            line  <= '0;
        end else begin
            state <= state_nxt;
            if (req_ready && req_valid) base <= req_addr[31:2];
            if (state == ST_ADDR) cnt <= '0;
            else if (capture) cnt <= cnt + 2'd1;
            if (capture) line[{d_slot, 5'b0} +: 32] <= hrdata;
        end
    end

`ifdef ICACHE_CRIT_WORD_FWD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= capture && cnt == 2'd0;
            if (capture && cnt == 2'd0) crit_data <= hrdata;
        end
    end
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized self-checking bench with a transaction-level refill model and AHB slave
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    logic         clk = 1'b0, rst = 1'b1, req_valid = 1'b0, hready = 1'b1, hresp = 1'b0;
    logic [31:0]  req_addr = '0, hrdata = '0;
    logic         req_ready, fill_valid, crit_valid, err_valid, hwrite;
    logic [8:0]   fill_index;
    logic [18:0]  fill_tag;
    logic [127:0] fill_line;
    logic [31:0]  crit_data, haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst, hsize;

    icache_refill_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag), .fill_line(fill_line),
        .crit_valid(crit_valid), .crit_data(crit_data), .err_valid(err_valid),
        .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
        .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // stimulus knobs
    bit          want_rst = 1'b1, want_valid = 1'b0, rand_ready = 1'b0;
    logic [31:0] want_addr = '0;
    bit          hr_q[$];
    int          err_beat = -1;

    // model / slave state
    int          cyc = 0, ones, dbeat, issued, fill_due = -1, crit_due = -1, err_phase = 0;
    int          acc_cyc, fill_cyc, crit_cyc, saw_err, saw_fill;
    bit          busy = 1'b0, pend = 1'b0, accepted;
    logic [31:0] pend_addr, cur_addr, exp_crit;
    logic [31:0] exp_q[$];
    logic [127:0] exp_line, last_line;
    logic [18:0] last_tag;
    logic [8:0]  last_idx;

    task automatic step();
        logic s_hr;
        logic [1:0] s_tr;
        logic [31:0] s_ha, base;
        #1;
        rst = want_rst;
        req_valid = want_valid;
        req_addr = want_addr;
        if (err_phase == 1) begin
            hready = 1'b1; hresp = 1'b1; err_phase = 2;
        end else if (pend && busy && err_phase == 0 && dbeat == err_beat) begin
            hready = 1'b0; hresp = 1'b1; err_phase = 1; err_beat = -1;
        end else begin
            hresp = 1'b0;
            hready = hr_q.size() != 0 ? hr_q.pop_front() : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
        hrdata = pend ? mem(pend_addr) : $urandom;
        #1;
        s_hr = hready; s_tr = htrans; s_ha = haddr;
        if (!rst) begin
            check("req_ready", req_ready, !busy);
            check("err_valid", err_valid, err_phase == 2);
            check("fill_valid", fill_valid, cyc == fill_due);
            if (fill_valid) begin
                saw_fill++; fill_cyc = cyc;
                last_line = fill_line; last_tag = fill_tag; last_idx = fill_index;
                check("fill_line", fill_line, exp_line);
                check("fill_index", fill_index, cur_addr[12:4]);
                check("fill_tag", fill_tag, cur_addr[31:13]);
            end
            if (err_valid) saw_err++;
`ifdef ICACHE_CRIT_WORD_FWD_EN
            check("crit_valid", crit_valid, cyc == crit_due);
            if (crit_valid) begin
                crit_cyc = cyc;
                check("crit_data", crit_data, exp_crit);
            end
`else
            check("crit_valid", crit_valid, 1'b0);
            check("crit_data", crit_data, 32'h0);
`endif
            if (err_phase == 2) check("htrans_err", htrans, HT_IDLE);
            else if (err_phase != 1 && htrans != HT_IDLE) begin
                if (exp_q.size() == 0) check("htrans_extra", htrans, HT_IDLE);
                else begin
                    check("haddr", haddr, exp_q[0]);
                    check("htrans", htrans, issued == 0 ? HT_NONSEQ : HT_SEQ);
                    check("hburst", hburst, BURST_WRAP4);
                    check("hsize", hsize, HSIZE_WORD);
                    check("hwrite", hwrite, 1'b0);
                end
            end
            if (!busy) check("hburst_idle", hburst, BURST_SINGLE);
        end
        @(posedge clk);
        accepted = 1'b0;
        if (rst) begin
            busy = 0; pend = 0; err_phase = 0; exp_q.delete(); fill_due = -1; crit_due = -1;
        end else begin
            if (req_valid && !busy) begin
                accepted = 1; busy = 1; acc_cyc = cyc; cur_addr = req_addr;
                ones = 0; dbeat = 0; issued = 0; exp_q.delete();
                base = {req_addr[31:4], 4'h0};
                for (int n = 0; n < 4; n++) begin
                    exp_q.push_back(base + 32'(((int'(req_addr[3:2]) + n) % 4) * 4));
                    exp_line[32*n +: 32] = mem(base + 32'(4 * n));
                end
                exp_crit = mem({req_addr[31:2], 2'b00});
            end else if (busy) begin
                if (err_phase == 1) begin
                    fill_due = -1; exp_q.delete(); ones = 99;
                end else if (err_phase == 2) begin
                    busy = 0; err_phase = 0;
                end else if (cyc == fill_due) busy = 0;
                else if (s_hr && ones < 5) begin
                    // addr0 + four data beats each need one ready cycle
                    ones++;
                    if (ones == 2) crit_due = cyc + 1;
                    if (ones == 5) fill_due = cyc + 1;
                end
            end
            if (s_hr) begin
                if (pend) dbeat++;
                pend = s_tr != HT_IDLE;
                pend_addr = s_ha;
                if (pend && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    issued++;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_req(input logic [31:0] a);
        int n;
        saw_err = 0; saw_fill = 0;
        want_valid = 1; want_addr = a;
        n = 0;
        do begin step(); n++; end while (!accepted && n < 50);
        want_valid = 0;
        check("accept", accepted, 1'b1);
        n = 0;
        while (busy && n < 300) begin step(); n++; end
        check("done", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        step(); step();
        want_rst = 0;
        step();
        #1;
        check("rst_fill_line", fill_line, 128'h0);
        check("rst_fill_index", fill_index, 9'h0);
        check("rst_fill_tag", fill_tag, 19'h0);
        check("rst_crit_data", crit_data, 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_htrans", htrans, HT_IDLE);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_fill_valid", fill_valid, 1'b0);
        check("rst_err_valid", err_valid, 1'b0);

        // zero-wait miss
        run_req(32'h0000_1238);
        check("t1_latency", fill_cyc - acc_cyc, 6);
        check("t1_line", last_line, {mem(32'h123C), mem(32'h1238), mem(32'h1234), mem(32'h1230)});
        check("t1_index", last_idx, 9'h123);
        check("t1_tag", last_tag, 19'h0);
`ifdef ICACHE_CRIT_WORD_FWD_EN
        check("t6_crit_latency", crit_cyc - acc_cyc, 3);
`endif

        // two wait states on beat 1 address phase
        hr_q = '{1'b1, 1'b1, 1'b0, 1'b0};
        run_req(32'h0000_1238);
        check("t2_latency", fill_cyc - acc_cyc, 8);
        check("t2_line", last_line, {mem(32'h123C), mem(32'h1238), mem(32'h1234), mem(32'h1230)});

        // error on beat 2 data phase
        err_beat = 2;
        run_req(32'h0000_1238);
        check("t3_err", saw_err, 1);
        check("t3_nofill", saw_fill, 0);

        // back-to-back requests with req_valid held high
        want_valid = 1; want_addr = 32'h0000_0040;
        do step(); while (!accepted && cyc < 1000);
        t0 = acc_cyc;
        want_addr = 32'h8000_0010;
        do step(); while (!accepted && cyc < 1000);
        check("t4_gap", acc_cyc - t0, 7);
        want_valid = 0;
        for (int n = 0; n < 50 && busy; n++) step();
        check("t4_tag", last_tag, 19'h40000);
        check("t4_idx", last_idx, 9'h001);

        // reset mid-burst
        saw_err = 0; saw_fill = 0;
        want_valid = 1; want_addr = 32'h0000_2224;
        step();
        want_valid = 0;
        step(); step();
        want_rst = 1;
        step();
        want_rst = 0;
        step();
        check("t5_ready", req_ready, 1'b1);
        check("t5_htrans", htrans, HT_IDLE);
        check("t5_nofill", saw_fill, 0);
        check("t5_noerr", saw_err, 0);
        run_req(32'h0000_2224);
        check("t5_refill", saw_fill, 1);

        // randomized traffic with wait states and occasional errors
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) step();
            err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_req($urandom);
            check("rand_outcome", saw_fill + saw_err, 1);
        end
        err_beat = -1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
